mvm_psum_accum: RTL

//  Downstream of mvm_engine. Accumulates its per-column partial sums y over cfg_n_tiles row-tiles of a larger matrix.

---
 rtl/mvm_pkg.sv | 17 +
 rtl/mvm_requant.sv | 46 ++++
 rtl/mvm_psum_accum.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mvm_pkg.sv
// Shared types and default lane widths for the mvm partial-sum accumulator slice.
// MVM_ACC_ROUND_EN (optional define) switches requantization to round half-up.
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } psum_state_e;

  localparam int MAT_W     = 3;
  localparam int IN_BITS   = 18;
  localparam int ACC_BITS  = 24;
  localparam int OUT_BITS  = 8;
  localparam int MAX_TILES = 16;

endpackage

// File: rtl/mvm_requant.sv
// One-lane combinational requantizer: right shift, optional round half-up, saturate.
// Rounding is enabled by defining MVM_ACC_ROUND_EN; default build truncates.
module mvm_requant
  import mvm_pkg::*;
#(
  parameter int accBits   = ACC_BITS,
  parameter int outBits   = OUT_BITS,
  parameter int shiftBits = $clog2(accBits)
) (
  input  logic [accBits-1:0]   acc,
  input  logic [shiftBits-1:0] shift,
  output logic [outBits-1:0]   q
);

  localparam logic [accBits-1:0] OUT_MAX = {{(accBits-outBits){1'b0}}, {outBits{1'b1}}};

  logic [accBits-1:0] rounded;
  logic [accBits-1:0] shifted;

`ifdef MVM_ACC_ROUND_EN
  logic [accBits:0] bias;
  logic [accBits:0] biased;

  // The half-LSB bias saturates at the accumulator width before shifting.
  always_comb begin
    bias = '0;
    if (shift != '0) begin
      bias = {{accBits{1'b0}}, 1'b1} << (shift - shiftBits'(1));
    end
    biased  = {1'b0, acc} + bias;
    rounded = biased[accBits] ? {accBits{1'b1}} : biased[accBits-1:0];
  end
`else
  assign rounded = acc;
`endif

  assign shifted = rounded >> shift;

  always_comb begin
    q = shifted[outBits-1:0];
    if (shifted > OUT_MAX) begin
      q = {outBits{1'b1}};
    end
  end

endmodule

// File: rtl/mvm_psum_accum.sv
// Accumulates mvm_engine column partial sums over several row tiles, then
// requantizes each lane and hands one vector out per job (MVM_ACC_ROUND_EN selects rounding).
module mvm_psum_accum
  import mvm_pkg::*;
#(
  parameter int matW     = MAT_W,
  parameter int inBits   = IN_BITS,
  parameter int accBits  = ACC_BITS,
  parameter int outBits  = OUT_BITS,
  parameter int maxTiles = MAX_TILES,
  parameter int tileW    = $clog2(maxTiles+1),
  parameter int shiftW   = $clog2(accBits)
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            start_i,
  input  logic [tileW-1:0]                cfg_n_tiles_i,
  input  logic [shiftW-1:0]               cfg_shift_i,
  input  logic [matW-1:0][inBits-1:0]     y_i,
  input  logic                            y_valid_i,
  output logic                            y_ready_o,
  output logic [matW-1:0][outBits-1:0]    q_o,
  output logic                            q_valid_o,
  input  logic                            q_ready_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            acc_sat_o
);

  psum_state_e state, state_next;

  logic [matW-1:0][accBits-1:0] acc;
  logic [tileW-1:0]             tile_cnt;
  logic [tileW-1:0]             n_tiles;
  logic [shiftW-1:0]            shift;
  logic                         acc_sat;

  logic                         beat_fire;
  logic                         last_beat;
  logic [matW-1:0][accBits:0]   lane_sum;
  logic [matW-1:0][accBits-1:0] lane_next;
  logic [matW-1:0]              lane_ovf;

  assign beat_fire = y_valid_i && y_ready_o;
  assign last_beat = (tile_cnt == n_tiles - tileW'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    y_ready_o  = 1'b0;
    q_valid_o  = 1'b0;
    done_o     = 1'b0;
    busy_o     = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start_i) state_next = ACCUM;
      end
      ACCUM: begin
        y_ready_o = 1'b1;
        if (y_valid_i && last_beat) state_next = EMIT;
      end
      EMIT: begin
        q_valid_o = 1'b1;
        if (q_ready_i) begin
          done_o     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Saturating lane adders; the carry out doubles as the saturation flag.
  always_comb begin
    lane_sum  = '0;
    lane_next = '0;
    lane_ovf  = '0;
    for (int k = 0; k < matW; k++) begin
      lane_sum[k]  = {1'b0, acc[k]} + {{(accBits+1-inBits){1'b0}}, y_i[k]};
      lane_ovf[k]  = lane_sum[k][accBits];
      lane_next[k] = lane_ovf[k] ? {accBits{1'b1}} : lane_sum[k][accBits-1:0];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc      <= '0;
      tile_cnt <= '0;
      n_tiles  <= '0;
      shift    <= '0;
      acc_sat  <= 1'b0;
    end else if (state == IDLE && start_i) begin
      n_tiles  <= (cfg_n_tiles_i == '0) ? tileW'(1) : cfg_n_tiles_i;
      shift    <= cfg_shift_i;
      acc      <= '0;
      tile_cnt <= '0;
      acc_sat  <= 1'b0;
    end else if (beat_fire) begin
      acc      <= lane_next;
      tile_cnt <= tile_cnt + tileW'(1);
      if (|lane_ovf) acc_sat <= 1'b1;
    end
  end

  assign acc_sat_o = acc_sat;

  // Output lanes look only at registered state, never at y_i.
  for (genvar g = 0; g < matW; g++) begin : g_requant
    mvm_requant #(
      .accBits   (accBits),
      .outBits   (outBits),
      .shiftBits (shiftW)
    ) u_requant (
      .acc   (acc[g]),
      .shift (shift),
      .q     (q_o[g])
    );
  end

endmodule
